// File: rtl/arc4_pkg.sv
// Shared types and constants for the ARC4 decryption pass sequencer.
package arc4_pkg;

    localparam int KEY_W_DEF = 24;
    localparam int S_ADDR_W  = 8;
    localparam int S_DATA_W  = 8;

    localparam logic [1:0] PH_IDLE = 2'd0;
    localparam logic [1:0] PH_INIT = 2'd1;
    localparam logic [1:0] PH_KSA  = 2'd2;
    localparam logic [1:0] PH_PRGA = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        INIT_REQ,
        INIT_RUN,
        KSA_REQ,
        KSA_RUN,
        PRGA_REQ,
        PRGA_RUN
    } arc4_seq_state_t;

    function automatic logic [1:0] phase_of(arc4_seq_state_t s);
        case (s)
            INIT_REQ, INIT_RUN: phase_of = PH_INIT;
            KSA_REQ, KSA_RUN:   phase_of = PH_KSA;
            PRGA_REQ, PRGA_RUN: phase_of = PH_PRGA;
            default:            phase_of = PH_IDLE;
        endcase
    endfunction

    function automatic logic in_run(arc4_seq_state_t s);
        in_run = (s == INIT_RUN) || (s == KSA_RUN) || (s == PRGA_RUN);
    endfunction

endpackage

// File: rtl/arc4_smux.sv
// S-memory port mux: grants the single S port to the requester of the
// current phase; idle drives an inert all-zero access.
module arc4_smux
    import arc4_pkg::*;
(
    input  logic [1:0]          phase,
    input  logic [S_ADDR_W-1:0] init_s_addr,
    input  logic [S_DATA_W-1:0] init_s_wrdata,
    input  logic                init_s_wren,
    input  logic [S_ADDR_W-1:0] ksa_s_addr,
    input  logic [S_DATA_W-1:0] ksa_s_wrdata,
    input  logic                ksa_s_wren,
    input  logic [S_ADDR_W-1:0] prga_s_addr,
    input  logic [S_DATA_W-1:0] prga_s_wrdata,
    input  logic                prga_s_wren,
    output logic [S_ADDR_W-1:0] s_addr,
    output logic [S_DATA_W-1:0] s_wrdata,
    output logic                s_wren
);

    always_comb begin
        s_addr   = '0;
        s_wrdata = '0;
        s_wren   = 1'b0;
        case (phase)
            PH_INIT: begin
                s_addr   = init_s_addr;
                s_wrdata = init_s_wrdata;
                s_wren   = init_s_wren;
            end
            PH_KSA: begin
                s_addr   = ksa_s_addr;
                s_wrdata = ksa_s_wrdata;
                s_wren   = ksa_s_wren;
            end
            PH_PRGA: begin
                s_addr   = prga_s_addr;
                s_wrdata = prga_s_wrdata;
                s_wren   = prga_s_wren;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/arc4_seq.sv
// ARC4 pass sequencer: runs init -> ksa -> prga and owns the S-port grant.
// Optional per-phase watchdog enabled by defining ARC4_SEQ_TIMEOUT_EN.
module arc4_seq
    import arc4_pkg::*;
#(
    parameter int KEY_W          = KEY_W_DEF,
    parameter int TIMEOUT_CYCLES = 4095
)
(
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    output logic                rdy,
    input  logic [KEY_W-1:0]    key,
    output logic [KEY_W-1:0]    key_o,
    output logic                init_en,
    output logic                ksa_en,
    output logic                prga_en,
    input  logic                init_rdy,
    input  logic                ksa_rdy,
    input  logic                prga_rdy,
    input  logic [S_ADDR_W-1:0] init_s_addr,
    input  logic [S_ADDR_W-1:0] ksa_s_addr,
    input  logic [S_ADDR_W-1:0] prga_s_addr,
    input  logic [S_DATA_W-1:0] init_s_wrdata,
    input  logic [S_DATA_W-1:0] ksa_s_wrdata,
    input  logic [S_DATA_W-1:0] prga_s_wrdata,
    input  logic                init_s_wren,
    input  logic                ksa_s_wren,
    input  logic                prga_s_wren,
    output logic [S_ADDR_W-1:0] s_addr,
    output logic [S_DATA_W-1:0] s_wrdata,
    output logic                s_wren,
    output logic [1:0]          phase,
    output logic                err
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    arc4_seq_state_t  state_q, state_d;
    logic [KEY_W-1:0] key_q;
    logic             accept;

`ifdef ARC4_SEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    logic [WD_W-1:0] wd_q;
    logic            err_q;
    logic            tmo;
`endif

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        init_en = 1'b0;
        ksa_en  = 1'b0;
        prga_en = 1'b0;
        case (state_q)
            IDLE: if (en) begin
                accept  = 1'b1;
                state_d = INIT_REQ;
            end
            INIT_REQ: if (init_rdy) begin
                init_en = 1'b1;
                state_d = INIT_RUN;
            end
            INIT_RUN: if (init_rdy) state_d = KSA_REQ;
            KSA_REQ: if (ksa_rdy) begin
                ksa_en  = 1'b1;
                state_d = KSA_RUN;
            end
            KSA_RUN: if (ksa_rdy) state_d = PRGA_REQ;
            PRGA_REQ: if (prga_rdy) begin
                prga_en = 1'b1;
                state_d = PRGA_RUN;
            end
            PRGA_RUN: if (prga_rdy) state_d = IDLE;
            default: state_d = IDLE;
        endcase
`ifdef ARC4_SEQ_TIMEOUT_EN
        tmo = 1'b0;
        // a sub-block that finishes on the last allowed cycle still wins
        if (in_run(state_q) && state_d == state_q && wd_q == WD_LAST) begin
            tmo     = 1'b1;
            state_d = IDLE;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            key_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) key_q <= key;
        end
    end

`ifdef ARC4_SEQ_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wd_q <= in_run(state_q) ? wd_q + 1'b1 : '0;
            if (accept)   err_q <= 1'b0;
            else if (tmo) err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign rdy   = (state_q == IDLE);
    assign key_o = key_q;
    assign phase = phase_of(state_q);

    arc4_smux u_smux (
        .phase         (phase),
        .init_s_addr   (init_s_addr),
        .init_s_wrdata (init_s_wrdata),
        .init_s_wren   (init_s_wren),
        .ksa_s_addr    (ksa_s_addr),
        .ksa_s_wrdata  (ksa_s_wrdata),
        .ksa_s_wren    (ksa_s_wren),
        .prga_s_addr   (prga_s_addr),
        .prga_s_wrdata (prga_s_wrdata),
        .prga_s_wren   (prga_s_wren),
        .s_addr        (s_addr),
        .s_wrdata      (s_wrdata),
        .s_wren        (s_wren)
    );

endmodule

// File: tb/tb_arc4_seq.sv
// Scoreboard bench for arc4_seq with behavioural init/ksa/prga models.
// The timeout scenario runs only when ARC4_SEQ_TIMEOUT_EN is defined.
module tb_arc4_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        rdy;
    logic [23:0] key = '0;
    logic [23:0] key_o;
    logic        init_en, ksa_en, prga_en;
    logic        init_rdy, ksa_rdy, prga_rdy;
    logic [7:0]  s_addr, s_wrdata;
    logic        s_wren;
    logic [1:0]  phase;
    logic        err;

    logic        init_wren = 1'b1;
    logic        ksa_block = 1'b0;
    logic        prga_hang = 1'b0;
    int          icnt, kcnt, pcnt;

    int n_checks = 0;
    int n_fail   = 0;
    int rst_cnt  = 0;
    int edge_n   = 0;

    localparam int LAT_FULL = 3 + 256 + 768 + 40;

    typedef struct {
        int          kind;
        logic [1:0]  ph;
        logic [23:0] k;
        logic [7:0]  addr;
        logic [7:0]  data;
        logic        wren;
        int          lat;
        logic        e;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    arc4_seq #(.KEY_W(24), .TIMEOUT_CYCLES(100)) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .rdy           (rdy),
        .key           (key),
        .key_o         (key_o),
        .init_en       (init_en),
        .ksa_en        (ksa_en),
        .prga_en       (prga_en),
        .init_rdy      (init_rdy),
        .ksa_rdy       (ksa_rdy),
        .prga_rdy      (prga_rdy),
        .init_s_addr   (8'h11),
        .ksa_s_addr    (8'h12),
        .prga_s_addr   (8'h13),
        .init_s_wrdata (8'h21),
        .ksa_s_wrdata  (8'h22),
        .prga_s_wrdata (8'h23),
        .init_s_wren   (init_wren),
        .ksa_s_wren    (1'b1),
        .prga_s_wren   (1'b1),
        .s_addr        (s_addr),
        .s_wrdata      (s_wrdata),
        .s_wren        (s_wren),
        .phase         (phase),
        .err           (err)
    );

    // sub-block models: run length N means N cycles in the RUN state
    always @(posedge clk or posedge rst) begin
        if (rst) icnt <= 0;
        else if (init_en) icnt <= 255;
        else if (icnt != 0) icnt <= icnt - 1;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) kcnt <= 0;
        else if (ksa_en) kcnt <= 767;
        else if (kcnt != 0) kcnt <= kcnt - 1;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) pcnt <= 0;
        else if (prga_en) pcnt <= prga_hang ? 1000000 : 39;
        else if (pcnt != 0) pcnt <= pcnt - 1;
    end

    assign init_rdy = (icnt == 0);
    assign ksa_rdy  = (kcnt == 0) && !ksa_block;
    assign prga_rdy = (pcnt == 0);

    always @(posedge clk) edge_n <= edge_n + 1;

    function automatic void check(string name, logic [31:0] act, logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endfunction

    task automatic push_pass(logic [23:0] k, int lat, logic iw, logic e, int upto);
        for (int i = 1; i <= upto; i++) begin
            exp_t x;
            x.kind = i;
            x.k    = k;
            x.lat  = lat;
            x.e    = e;
            case (i)
                1: begin x.ph = 2'd1; x.addr = 8'h11; x.data = 8'h21; x.wren = iw; end
                2: begin x.ph = 2'd2; x.addr = 8'h12; x.data = 8'h22; x.wren = 1'b1; end
                3: begin x.ph = 2'd3; x.addr = 8'h13; x.data = 8'h23; x.wren = 1'b1; end
                default: begin x.ph = 2'd0; x.addr = 8'h00; x.data = 8'h00; x.wren = 1'b0; end
            endcase
            sb.push_back(x);
        end
    endtask

    // monitor: every en pulse and every rdy rise is a DUT event to score
    int   t0 = 0;
    int   rst_seen = 0;
    logic rdy_prev = 1'b1;
    exp_t got;

    always @(negedge clk) begin
        int ev;
        int nen;
        if (rst_cnt != rst_seen) begin
            rst_seen = rst_cnt;
            rdy_prev = rdy;
        end else begin
            if (rdy && en) t0 = edge_n + 1;
            ev  = 0;
            nen = int'(init_en) + int'(ksa_en) + int'(prga_en);
            if (nen > 1) check("en_onehot", nen, 1);
            if (init_en) ev = 1;
            if (ksa_en)  ev = 2;
            if (prga_en) ev = 3;
            if (rdy && !rdy_prev) ev = 4;
            if (ev != 0) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected", ev, 0);
                end else begin
                    got = sb.pop_front();
                    check("ev_kind", ev, got.kind);
                    check("ev_phase", phase, got.ph);
                    check("ev_key_o", key_o, got.k);
                    check("ev_s_addr", s_addr, got.addr);
                    check("ev_s_wrdata", s_wrdata, got.data);
                    check("ev_s_wren", s_wren, got.wren);
                    if (ev == 4) begin
                        check("pass_latency", edge_n - t0, got.lat);
                        check("pass_err", err, got.e);
                    end
                end
            end
            rdy_prev = rdy;
        end
    end

    task automatic start_pass(logic [23:0] k);
        @(posedge clk);
        #1;
        en  = 1'b1;
        key = k;
        @(posedge clk);
        #1;
        en = 1'b0;
    endtask

    task automatic wait_phase(logic [1:0] p, int limit);
        int n = 0;
        @(negedge clk);
        while (phase !== p && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (phase !== p) check("wait_phase_timeout", phase, p);
    endtask

    task automatic wait_done(int limit);
        int n = 0;
        @(negedge clk);
        while (rdy !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (rdy !== 1'b1) check("wait_rdy_timeout", rdy, 1);
        @(negedge clk);
        check("sb_drained", sb.size(), 0);
    endtask

    task automatic pulse_rst();
        @(posedge clk);
        #1;
        rst = 1'b1;
        rst_cnt++;
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_rdy", rdy, 1);
        check("rst_phase", phase, 0);
        check("rst_s_wren", s_wren, 0);
        check("rst_s_addr", s_addr, 0);
        check("rst_s_wrdata", s_wrdata, 0);
        check("rst_key_o", key_o, 0);
        check("rst_err", err, 0);
        check("rst_ens", {init_en, ksa_en, prga_en}, 0);

        // full pass, mux routing scored at each en pulse
        push_pass(24'h00033C, LAT_FULL, 1'b1, 1'b0, 4);
        start_pass(24'h00033C);
        wait_done(2000);

        // en held high with a new key during ksa must not restart
        push_pass(24'h00033C, LAT_FULL, 1'b1, 1'b0, 4);
        start_pass(24'h00033C);
        wait_phase(2'd2, 400);
        @(posedge clk);
        #1;
        en  = 1'b1;
        key = 24'h1ABCDE;
        repeat (20) @(posedge clk);
        #1;
        en = 1'b0;
        check("hold_key_o", key_o, 24'h00033C);
        check("hold_phase", phase, 2);
        wait_done(2000);

        // ksa_rdy low 5 cycles in KSA_REQ; init wren off must reach s_wren
        ksa_block = 1'b1;
        init_wren = 1'b0;
        push_pass(24'h0A0B0C, LAT_FULL + 5, 1'b0, 1'b0, 4);
        start_pass(24'h0A0B0C);
        wait_phase(2'd2, 400);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            check("ksa_req_no_en", ksa_en, 0);
            check("ksa_req_phase", phase, 2);
        end
        @(posedge clk);
        #1;
        ksa_block = 1'b0;
        wait_done(2000);
        init_wren = 1'b1;

        // async reset mid-ksa, then a clean pass
        push_pass(24'h5A5A5A, 0, 1'b1, 1'b0, 2);
        start_pass(24'h5A5A5A);
        repeat (499) @(posedge clk);
        pulse_rst();
        check("mid_rst_rdy", rdy, 1);
        check("mid_rst_s_wren", s_wren, 0);
        check("mid_rst_phase", phase, 0);
        check("mid_rst_key_o", key_o, 0);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_sb", sb.size(), 0);
        push_pass(24'h00033C, LAT_FULL, 1'b1, 1'b0, 4);
        start_pass(24'h00033C);
        wait_done(2000);

`ifdef ARC4_SEQ_TIMEOUT_EN
        // prga never finishes: watchdog releases after 100 RUN cycles
        prga_hang = 1'b1;
        push_pass(24'h00C0DE, 3 + 256 + 768 + 100, 1'b1, 1'b1, 4);
        start_pass(24'h00C0DE);
        wait_done(2000);
        check("tmo_err", err, 1);
        check("tmo_rdy", rdy, 1);
        push_pass(24'h000777, 0, 1'b1, 1'b0, 1);
        start_pass(24'h000777);
        @(negedge clk);
        check("tmo_err_cleared", err, 0);
        @(negedge clk);
        check("tmo_sb", sb.size(), 0);
        pulse_rst();
        prga_hang = 1'b0;
        rst = 1'b0;
        @(negedge clk);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
